// File: rtl/lot_pkg.sv
`default_nettype none
//==============================================================================
// lot_pkg -- constants and FSM encoding shared by the lottery front end and checker
// rev 1.0
//==============================================================================
package lot_pkg;

    localparam logic [3:0] MAX_DIGIT          = 4'd9;
    localparam int         NUM_DIGITS_DEFAULT = 5;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FIM     = 2'd1,
        DONE    = 2'd2
    } lot_state_e;

endpackage
`default_nettype wire

// File: rtl/lot_debounce.sv
`default_nettype none
//==============================================================================
// lot_debounce -- 2-flop synchroniser, stability counter and rising-edge pulse
// rev 1.0
//==============================================================================
module lot_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The flip happens on the sample that would make the count reach DEBOUNCE_CYCLES,
    // and the press pulse is registered on that same edge.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/lot_digit_entry.sv
`default_nettype none
//==============================================================================
// lot_digit_entry -- debounced digit entry front end for the lottery checker
// rev 1.0
//==============================================================================
module lot_digit_entry
    import lot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_DIGITS      = NUM_DIGITS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn_insere,
    input  logic       btn_fim_jogo,
    output logic [3:0] num,
    output logic       insere,
    output logic       fim,
    output logic       fim_jogo,
    output logic [2:0] digit_cnt,
    output logic       err
);

    localparam logic [2:0] CNT_MAX = 3'(NUM_DIGITS);

    logic [3:0] sw_s1_q, sw_s2_q;
    logic       ins_press, fj_press;
    logic       unused_ins_level, unused_fj_level;

    lot_state_e state_q, state_d;
    logic [3:0] num_q, num_d;
    logic [2:0] cnt_q, cnt_d;
    logic       insere_q, insere_d;
    logic       fim_q, fim_d;
    logic       fim_jogo_q, fim_jogo_d;
    logic       err_q, err_d;

    lot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_insere (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_insere),
        .level (unused_ins_level),
        .press (ins_press)
    );

    lot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fim_jogo (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_fim_jogo),
        .level (unused_fj_level),
        .press (fj_press)
    );

    // A new-game press overrides everything, including a pending fim pulse.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        insere_d   = 1'b0;
        fim_d      = 1'b0;
        fim_jogo_d = 1'b0;
        err_d      = 1'b0;
        if (fj_press) begin
            fim_jogo_d = 1'b1;
            cnt_d      = '0;
            num_d      = '0;
            state_d    = COLLECT;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (ins_press) begin
                        if (sw_s2_q <= MAX_DIGIT) begin
                            num_d    = sw_s2_q;
                            insere_d = 1'b1;
                            if (cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + 3'd1;
                            end
                            if (cnt_q + 3'd1 == CNT_MAX) begin
                                state_d = FIM;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                FIM: begin
                    fim_d   = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            state_q    <= COLLECT;
            num_q      <= '0;
            cnt_q      <= '0;
            insere_q   <= 1'b0;
            fim_q      <= 1'b0;
            fim_jogo_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
            state_q    <= state_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            insere_q   <= insere_d;
            fim_q      <= fim_d;
            fim_jogo_q <= fim_jogo_d;
            err_q      <= err_d;
        end
    end

    assign num       = num_q;
    assign insere    = insere_q;
    assign fim       = fim_q;
    assign fim_jogo  = fim_jogo_q;
    assign digit_cnt = cnt_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lot_digit_entry.sv
`default_nettype none
//==============================================================================
// tb_lot_digit_entry -- scoreboard bench for lot_digit_entry (DEBOUNCE_CYCLES=4, NUM_DIGITS=5)
// rev 1.0
//==============================================================================
module tb_lot_digit_entry;

    localparam int ND     = 5;
    localparam int LAT    = 7;  // cyc value at the sampling edge is k+1; pulse visible 6 edges later
    localparam int K_INS  = 1;
    localparam int K_ERR  = 2;
    localparam int K_FIM  = 3;
    localparam int K_FJ   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       btn_insere;
    logic       btn_fim_jogo;
    logic [3:0] num;
    logic       insere;
    logic       fim;
    logic       fim_jogo;
    logic [2:0] digit_cnt;
    logic       err;

    lot_digit_entry #(.DEBOUNCE_CYCLES(4), .NUM_DIGITS(ND)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .btn_insere   (btn_insere),
        .btn_fim_jogo (btn_fim_jogo),
        .num          (num),
        .insere       (insere),
        .fim          (fim),
        .fim_jogo     (fim_jogo),
        .digit_cnt    (digit_cnt),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [3:0] num;
        logic [2:0] cnt;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // reference model of the ticket state
    logic [3:0] m_num;
    int         m_cnt;
    bit         m_done;

    function automatic void expect_ev(input int k, input logic [3:0] n, input logic [2:0] c, input int cy);
        exp_t e;
        e.kind = k;
        e.num  = n;
        e.cnt  = c;
        e.cyc  = cy;
        sbq.push_back(e);
    endfunction

    // output monitor: every pulse must match the head of the scoreboard
    int   mon_kind;
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset === 1'b0 && (insere | fim | fim_jogo | err)) begin
            mon_kind = insere ? K_INS : err ? K_ERR : fim ? K_FIM : K_FJ;
            n_tests++;
            if ($countones({insere, fim, fim_jogo, err}) != 1) begin
                n_fail++;
                $display("FAIL exclusive: pulses ins/fim/fj/err=%b%b%b%b, required exactly one",
                         insere, fim, fim_jogo, err);
            end
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: kind %0d num %0d cnt %0d at cyc %0d, required none",
                         mon_kind, num, digit_cnt, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_kind !== mon_e.kind || num !== mon_e.num || digit_cnt !== mon_e.cnt || cyc != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got kind %0d num %0d cnt %0d cyc %0d, required kind %0d num %0d cnt %0d cyc %0d",
                             mon_kind, num, digit_cnt, cyc, mon_e.kind, mon_e.num, mon_e.cnt, mon_e.cyc);
                end
            end
        end
    end

    task automatic press_insere(input logic [3:0] d);
        int k;
        @(negedge clk);
        sw = d;
        repeat (3) @(negedge clk);
        btn_insere = 1'b1;
        k = cyc;
        if (!m_done) begin
            if (d > 4'd9) begin
                expect_ev(K_ERR, m_num, 3'(m_cnt), k + LAT);
            end else begin
                m_num = d;
                m_cnt++;
                expect_ev(K_INS, d, 3'(m_cnt), k + LAT);
                if (m_cnt == ND) begin
                    m_done = 1'b1;
                    expect_ev(K_FIM, d, 3'(m_cnt), k + LAT + 1);
                end
            end
        end
        repeat (10) @(negedge clk);
        btn_insere = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic press_new_game();
        int k;
        @(negedge clk);
        btn_fim_jogo = 1'b1;
        k = cyc;
        m_num  = 4'd0;
        m_cnt  = 0;
        m_done = 1'b0;
        expect_ev(K_FJ, 4'd0, 3'd0, k + LAT);
        repeat (10) @(negedge clk);
        btn_fim_jogo = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        sw           = 4'd0;
        btn_insere   = 1'b0;
        btn_fim_jogo = 1'b0;
        m_num        = 4'd0;
        m_cnt        = 0;
        m_done       = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (num !== 4'd0)       begin n_fail++; $display("FAIL reset_num: got %0d, required 0", num); end
        n_tests++; if (insere !== 1'b0)    begin n_fail++; $display("FAIL reset_insere: got %b, required 0", insere); end
        n_tests++; if (fim !== 1'b0)       begin n_fail++; $display("FAIL reset_fim: got %b, required 0", fim); end
        n_tests++; if (fim_jogo !== 1'b0)  begin n_fail++; $display("FAIL reset_fim_jogo: got %b, required 0", fim_jogo); end
        n_tests++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d, required 0", digit_cnt); end
        n_tests++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_press();
        press_insere(4'd4);
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d events outstanding, required 0", sbq.size()); sbq.delete(); end
        n_tests++; if (num !== 4'd4 || digit_cnt !== 3'd1) begin
            n_fail++; $display("FAIL single_hold: num %0d cnt %0d, required num 4 cnt 1", num, digit_cnt);
        end
    endtask

    task automatic test_bounce();
        @(negedge clk);
        sw = 4'd8;
        for (int i = 0; i < 10; i++) begin
            btn_insere = ~btn_insere;
            repeat (2) @(negedge clk);
        end
        btn_insere = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL bounce_drain: %0d events outstanding, required 0", sbq.size()); sbq.delete(); end
        n_tests++; if (num !== 4'd4 || digit_cnt !== 3'd1) begin
            n_fail++; $display("FAIL bounce_state: num %0d cnt %0d, required num 4 cnt 1", num, digit_cnt);
        end
    endtask

    task automatic test_full_ticket();
        logic [3:0] digits [5];
        digits = '{4'd4, 4'd7, 4'd0, 4'd1, 4'd9};
        press_new_game();
        for (int i = 0; i < 5; i++) press_insere(digits[i]);
        n_tests++; if (digit_cnt !== 3'd5) begin n_fail++; $display("FAIL full_cnt: got %0d, required 5", digit_cnt); end
        press_insere(4'd6);
        press_insere(4'hC);
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL full_drain: %0d events outstanding, required 0", sbq.size()); sbq.delete(); end
        n_tests++; if (digit_cnt !== 3'd5 || num !== 4'd9) begin
            n_fail++; $display("FAIL full_saturate: cnt %0d num %0d, required cnt 5 num 9", digit_cnt, num);
        end
    endtask

    task automatic test_err_digit();
        press_new_game();
        press_insere(4'hB);
        n_tests++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL err_cnt: got %0d, required 0", digit_cnt); end
        press_insere(4'd3);
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL err_drain: %0d events outstanding, required 0", sbq.size()); sbq.delete(); end
        n_tests++; if (num !== 4'd3 || digit_cnt !== 3'd1) begin
            n_fail++; $display("FAIL err_recover: num %0d cnt %0d, required num 3 cnt 1", num, digit_cnt);
        end
    endtask

    task automatic test_simultaneous();
        int k;
        press_new_game();
        press_insere(4'd2);
        press_insere(4'd5);
        @(negedge clk);
        sw = 4'd7;
        repeat (3) @(negedge clk);
        btn_insere   = 1'b1;
        btn_fim_jogo = 1'b1;
        k = cyc;
        m_num = 4'd0;
        m_cnt = 0;
        expect_ev(K_FJ, 4'd0, 3'd0, k + LAT);
        repeat (10) @(negedge clk);
        btn_insere   = 1'b0;
        btn_fim_jogo = 1'b0;
        repeat (8) @(negedge clk);
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL simul_drain: %0d events outstanding, required 0", sbq.size()); sbq.delete(); end
        n_tests++; if (num !== 4'd0 || digit_cnt !== 3'd0) begin
            n_fail++; $display("FAIL simul_state: num %0d cnt %0d, required num 0 cnt 0", num, digit_cnt);
        end
    endtask

    task automatic test_async_reset();
        int k;
        press_new_game();
        press_insere(4'd2);
        @(negedge clk);
        sw = 4'd5;
        repeat (3) @(negedge clk);
        btn_insere = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++; if (digit_cnt !== 3'd0 || num !== 4'd0) begin
            n_fail++; $display("FAIL areset_state: cnt %0d num %0d, required cnt 0 num 0", digit_cnt, num);
        end
        n_tests++; if ({insere, fim, fim_jogo, err} !== 4'b0000) begin
            n_fail++; $display("FAIL areset_pulses: ins/fim/fj/err=%b%b%b%b, required 0000", insere, fim, fim_jogo, err);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = cyc;
        m_num  = 4'd5;
        m_cnt  = 1;
        m_done = 1'b0;
        expect_ev(K_INS, 4'd5, 3'd1, k + LAT);
        repeat (10) @(negedge clk);
        btn_insere = 1'b0;
        repeat (8) @(negedge clk);
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL areset_drain: %0d events outstanding, required 0", sbq.size()); sbq.delete(); end
        n_tests++; if (num !== 4'd5 || digit_cnt !== 3'd1) begin
            n_fail++; $display("FAIL areset_after: num %0d cnt %0d, required num 5 cnt 1", num, digit_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_full_ticket();
        test_err_digit();
        test_simultaneous();
        test_async_reset();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
